// File: rtl/ysyx_23060201_wbu.sv
// Writeback unit: retires one instruction at a time and issues a single-cycle GPR write plus commit pulse.
// Loads wait in WAIT_MEM for the response (bounded by TIMEOUT); misaligned, illegal and timed-out loads raise wb_err.
module ysyx_23060201_wbu #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_wen,
  input  logic                      in_is_load,
  input  logic [2:0]                in_funct3,
  input  logic [1:0]                in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_alu_res,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      commit_valid,
  output logic [DATA_WIDTH-1:0]     commit_pc,
  output logic                      wb_err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [GPR_ADDR_WIDTH-1:0] rd_q;
  logic                      wen_q;
  logic [2:0]                funct3_q;
  logic [1:0]                addr_lo_q;

  logic                      go, tmo, accept;
  logic                      s_load, s_wen;
  logic [DATA_WIDTH-1:0]     s_pc;
  logic [GPR_ADDR_WIDTH-1:0] s_rd;
  logic [2:0]                s_f3;
  logic [1:0]                s_lo;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [DATA_WIDTH-1:0]     ld_data, wdata_d;
  logic                      bad_f3, misal, err_d;

  assign in_ready = rst_n & (state_q == IDLE);
  assign accept   = (state_q == IDLE) & in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (!in_is_load || mem_rvalid) go = 1'b1;
          else                           state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + 8'd1;
        // Response arriving on the last allowed cycle still counts as success.
        if (mem_rvalid) begin
          go = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          go  = 1'b1;
          tmo = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (go) state_d = COMMIT;
  end

  // In IDLE the retiring fields come straight from the inputs; in WAIT_MEM from the latches.
  always_comb begin
    if (state_q == IDLE) begin
      s_load = in_is_load;
      s_pc   = in_pc;
      s_rd   = in_rd;
      s_wen  = in_wen;
      s_f3   = in_funct3;
      s_lo   = in_addr_lo;
    end else begin
      s_load = 1'b1;
      s_pc   = pc_q;
      s_rd   = rd_q;
      s_wen  = wen_q;
      s_f3   = funct3_q;
      s_lo   = addr_lo_q;
    end
  end

  always_comb begin
    ld_byte = mem_rdata[{s_lo, 3'b000} +: 8];
    ld_half = mem_rdata[{s_lo[1], 4'b0000} +: 16];
    bad_f3  = 1'b0;
    misal   = 1'b0;
    ld_data = '0;
    case (s_f3)
      3'b000: ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001: begin
        ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
        misal   = s_lo[0];
      end
      3'b010: begin
        ld_data = mem_rdata;
        misal   = (s_lo != 2'b00);
      end
      3'b100: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101: begin
        ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
        misal   = s_lo[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    err_d   = s_load & (bad_f3 | misal | tmo);
    wdata_d = err_d ? '0 : (s_load ? ld_data : in_alu_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
    end else if (accept) begin
      pc_q      <= in_pc;
      rd_q      <= in_rd;
      wen_q     <= in_wen;
      funct3_q  <= in_funct3;
      addr_lo_q <= in_addr_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_wen      <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      wb_err       <= 1'b0;
    end else begin
      gpr_wen      <= go & s_wen & (s_rd != '0) & ~err_d;
      gpr_waddr    <= go ? s_rd : '0;
      gpr_wdata    <= go ? wdata_d : '0;
      commit_valid <= go;
      commit_pc    <= go ? s_pc : '0;
      wb_err       <= go & err_d;
    end
  end

endmodule

// File: doc/ysyx_23060201_wbu.md
Name: ysyx_23060201_wbu

Overview:
- Writeback unit of the multicycle NPC; the initiator that drives the GPR write port (gpr_wen/gpr_waddr/gpr_wdata).
- Accepts one retiring instruction at a time from EXU/LSU over a valid/ready handshake.
- For loads, waits for the memory response, then aligns and extends the data.
- Issues a single-cycle GPR write plus a commit pulse for difftest; flags misaligned, illegal-width and timed-out loads.

Parameters:
- GPR_ADDR_WIDTH, 5, GPR index width.
- DATA_WIDTH, 32, datapath width.
- TIMEOUT, 255, max cycles spent in WAIT_MEM before abort; 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  WBU can accept.
- in_pc  in  32  PC of retiring instruction.
- in_rd  in  5  destination register.
- in_wen  in  1  instruction writes rd.
- in_is_load  in  1  result comes from memory.
- in_funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_addr_lo  in  2  load address bits [1:0].
- in_alu_res  in  32  result for non-loads.
- mem_rvalid  in  1  memory read data valid (single-cycle pulse).
- mem_rdata  in  32  aligned 32-bit word from memory.
- gpr_wen  out  1  GPR write enable.
- gpr_waddr  out  5  GPR write index.
- gpr_wdata  out  32  GPR write data.
- commit_valid  out  1  one-cycle retire pulse.
- commit_pc  out  32  PC of retired instruction.
- wb_err  out  1  one-cycle error pulse coincident with commit_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; counter cleared.
  - All registered outputs are 0.
  - in_ready is forced 0 while rst_n is low.
- Outputs: gpr_* and commit_* are registered; they are valid only in the COMMIT cycle and 0 otherwise, including gpr_waddr and gpr_wdata.
- States:
  - IDLE: in_ready=1. On in_valid, latch pc, rd, wen, funct3, addr_lo and alu_res.
    - Non-load: go to COMMIT.
    - Load with mem_rvalid=1 in the same cycle: latch mem_rdata and go to COMMIT.
    - Load otherwise: go to WAIT_MEM.
  - WAIT_MEM: in_ready=0; counter increments each cycle.
    - mem_rvalid=1: latch mem_rdata and go to COMMIT.
    - Counter reaches TIMEOUT with no mem_rvalid: go to COMMIT with the timeout flag set.
    - mem_rvalid in the same cycle the counter reaches TIMEOUT: the data wins and no error is raised.
  - COMMIT (exactly 1 cycle): in_ready=0; commit_valid=1; commit_pc=latched pc; next state IDLE; counter cleared.
- Write rule in COMMIT:
  - gpr_wen = wen & (rd != 0) & no error.
  - rd=0 never produces gpr_wen=1, but still commits.
- Latency and throughput:
  - Non-load: commit one cycle after acceptance; maximum throughput 1 instruction per 2 cycles.
  - mem_rvalid outside IDLE/WAIT_MEM is ignored.
- Load data formatting: byte = mem_rdata >> (8*addr_lo); half = mem_rdata >> (16*addr_lo[1]).
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Errors: wb_err=1, gpr_wen=0, gpr_wdata=0, commit still pulses, in these cases:
  - LH/LHU with addr_lo[0]=1.
  - LW with addr_lo != 0.
  - funct3 in {011, 110, 111} on a load.
  - Timeout.
- Misaligned or illegal loads still wait for mem_rvalid (the bus transaction completes); they are flagged only at commit.
- Reset mid-operation aborts the instruction with no write and no commit pulse.
- GPR timing: the GPR samples the write port on negedge clk. The gpr_* outputs are stable for the whole COMMIT cycle, which guarantees exactly one write per commit.

Test Plan:
- ALU writeback: in_valid, rd=5, wen=1, alu_res=0x1234_5678.
  - Required: commit next cycle, gpr_wen=1, waddr=5, wdata=0x12345678.
  - Required: in_ready=0 during commit and 1 the following cycle.
- rd=0 suppression: rd=0, wen=1, alu_res=0xFFFF_FFFF.
  - Required: commit_valid=1, gpr_wen=0.
- Load extension: mem_rdata=0x80FF_7F81 delivered 3 cycles after acceptance.
  - LB addr_lo=0 -> 0xFFFFFF81.
  - LBU addr_lo=1 -> 0x0000007F.
  - LH addr_lo=2 -> 0xFFFF80FF.
  - LHU addr_lo=2 -> 0x000080FF.
  - LW -> 0x80FF7F81.
  - Commit occurs the cycle after mem_rvalid.
- Same-cycle response: load accepted with mem_rvalid=1 in IDLE -> COMMIT next cycle, with no WAIT_MEM visit.
- Errors:
  - LW addr_lo=2 -> wb_err=1, gpr_wen=0, commit_valid=1.
  - LH addr_lo=1 -> same response.
  - funct3=011 -> same response.
- Timeout and reset:
  - Load with no mem_rvalid: wb_err and commit appear TIMEOUT+1 cycles after acceptance, with gpr_wen=0.
  - Deassert rst_n during WAIT_MEM: outputs go 0 asynchronously, no commit occurs, and in_ready=1 one cycle after rst_n rises.
